// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings used by the main decoder and
// the multiply/divide sequencer state type.
package cpu_pkg;

    localparam logic [3:0] OP_MUL  = 4'd5;
    localparam logic [3:0] OP_MFHI = 4'd6;
    localparam logic [3:0] OP_MFLO = 4'd7;
    localparam logic [3:0] OP_DIV  = 4'd8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } muldiv_state_t;

    // True for the opcodes that start an iterative HI/LO operation.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift registers, adder/subtractor and iteration counter for the
// multiply/divide sequencer. acc doubles as the MUL accumulator and the DIV
// remainder; mq doubles as the multiplier and the quotient; opnd holds the
// multiplicand or the divisor. The next-step values are exported so the
// controller can capture the final result on the last iteration edge.
module muldiv_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic             kind_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] mq_nxt,
    output logic             last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] opnd;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   mul_add;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             borrow;

    // One shift-add (MUL) or restoring-divide (DIV) step from the current state.
    always_comb begin
        sum     = {1'b0, acc} + {1'b0, opnd};
        mul_add = mq[0] ? sum : {1'b0, acc};
        // Partial remainder is always below the divisor, so the shifted value
        // fits WIDTH+1 bits and the difference's MSB is the borrow.
        trial   = {acc, mq[WIDTH-1]};
        diff    = trial - {1'b0, opnd};
        borrow  = diff[WIDTH];
        if (kind_div) begin
            acc_nxt = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
            mq_nxt  = {mq[WIDTH-2:0], ~borrow};
        end else begin
            acc_nxt = mul_add[WIDTH:1];
            mq_nxt  = {mul_add[0], mq[WIDTH-1:1]};
        end
    end

    assign last = (cnt == CW'(1));

    // Operand load on accept, one iteration per step.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc  <= '0;
            mq   <= '0;
            opnd <= '0;
            cnt  <= '0;
        end else if (load) begin
            acc  <= '0;
            mq   <= kind_div ? a : b;
            opnd <= kind_div ? b : a;
            cnt  <= CW'(WIDTH);
        end else if (step) begin
            acc  <= acc_nxt;
            mq   <= mq_nxt;
            cnt  <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, runs MUL/DIV iteratively through
// muldiv_datapath, stalls issue while busy and serves MFHI/MFLO reads.
// Handshake: an op is accepted at a rising edge when start=1, op is MUL/DIV
// and the sequencer is IDLE; otherwise the issuing stage holds it (stall=1)
// and re-presents it.
module muldiv_ctrl
    import cpu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_data
);

    muldiv_state_t    state;
    muldiv_state_t    state_nxt;

    logic             dp_load;
    logic             dp_step;
    logic             dp_kind_div;
    logic             dz_event;
    logic             complete;
    logic             last;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] mq_nxt;
    logic             b_zero;

    assign b_zero = (b == '0);

    muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (dp_load),
        .step     (dp_step),
        .kind_div (dp_kind_div),
        .a        (a),
        .b        (b),
        .acc_nxt  (acc_nxt),
        .mq_nxt   (mq_nxt),
        .last     (last)
    );

    // Next-state and datapath controls.
    always_comb begin
        state_nxt   = state;
        dp_load     = 1'b0;
        dp_step     = 1'b0;
        dp_kind_div = 1'b0;
        dz_event    = 1'b0;
        complete    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && op == OP_MUL) begin
                    dp_load   = 1'b1;
                    state_nxt = MUL_RUN;
                end else if (start && op == OP_DIV) begin
                    dp_kind_div = 1'b1;
                    if (b_zero) begin
                        dz_event = 1'b1;
                    end else begin
                        dp_load   = 1'b1;
                        state_nxt = DIV_RUN;
                    end
                end
            end
            MUL_RUN, DIV_RUN: begin
                dp_step     = 1'b1;
                dp_kind_div = (state == DIV_RUN);
                if (last) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // HI/LO are written only on completion or divide-by-zero; done follows by one cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= complete | dz_event;
            if (complete) begin
                hi <= acc_nxt;
                lo <= mq_nxt;
            end
            if (dz_event) begin
                hi       <= a;
                lo       <= '1;
                div_zero <= 1'b1;
            end else if (dp_load) begin
                div_zero <= 1'b0;
            end
        end
    end

    assign busy  = (state != IDLE);
    assign stall = reset_n &
                   (busy | ((state == IDLE) & start & is_muldiv(op) &
                            ~((op == OP_DIV) & b_zero)));

    // Combinational HI/LO read port for MFHI/MFLO.
    always_comb begin
        mf_data = '0;
        if (op == OP_MFHI)      mf_data = hi;
        else if (op == OP_MFLO) mf_data = lo;
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus randomized MUL/DIV
// traffic, with expected results queued at accept and checked on done.
module tb_muldiv_ctrl;

    localparam int W  = 8;
    localparam int EW = 2*W + 17;   // {cyc[15:0], dz, hi, lo}

    localparam logic [3:0] MUL  = 4'd5;
    localparam logic [3:0] MFHI = 4'd6;
    localparam logic [3:0] MFLO = 4'd7;
    localparam logic [3:0] DIV  = 4'd8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         stall;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] mf_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int stall_cnt;

    logic [EW-1:0] exp_q[$];
    logic [W-1:0]  mdl_hi;
    logic [W-1:0]  mdl_lo;

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo),
        .mf_data  (mf_data)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain unsigned arithmetic, returns {dz, hi, lo}.
    function automatic logic [2*W:0] ref_result(input logic [3:0] o, input logic [W-1:0] x,
                                                input logic [W-1:0] y);
        logic [2*W-1:0] p;
        if (o == MUL) begin
            p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            return {1'b0, p};
        end
        if (y == 0) return {1'b1, x, {W{1'b1}}};
        return {1'b0, W'(x % y), W'(x / y)};
    endfunction

    // Driver: present op until accepted (sequencer idle at the edge), then queue result.
    // Called and returns at posedge+1.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W:0] r;
        logic         acc_ok;
        int           n;
        start  = 1'b1;
        op     = o;
        a      = x;
        b      = y;
        acc_ok = 1'b0;
        n      = 0;
        while (!acc_ok && n < 100) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (!busy) acc_ok = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        op    = 4'd0;
        if (!acc_ok) begin
            chk("accept_timeout", 32'(n), 32'(0));
        end else begin
            r = ref_result(o, x, y);
            exp_q.push_back({16'(cyc + (r[2*W] ? 0 : W)), r});
            mdl_hi = r[2*W-1:W];
            mdl_lo = r[W-1:0];
        end
    endtask

    // Wait until every queued result has been seen; returns at posedge+1.
    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", 32'(exp_q.size()), 32'(0));
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (reset_n && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("res_hi",   32'(hi),       32'(e[2*W-1:W]));
                chk("res_lo",   32'(lo),       32'(e[W-1:0]));
                chk("res_dz",   32'(div_zero), 32'(e[2*W]));
                chk("done_cyc", 32'(cyc & 16'hFFFF), 32'(e[EW-1:2*W+1]));
            end
        end
    end

    initial begin
        logic [3:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] prev_hi;
        logic [W-1:0] prev_lo;
        logic [W-1:0] exp_mf;

        reset_n = 1'b0;
        start   = 1'b1;
        op      = MUL;
        a       = 8'd3;
        b       = 8'd3;
        mdl_hi  = '0;
        mdl_lo  = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall_in_reset", 32'(stall), 32'(0));
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = 4'd0;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_hi",   32'(hi),       32'(0));
        chk("rst_lo",   32'(lo),       32'(0));
        chk("rst_busy", 32'(busy),     32'(0));
        chk("rst_done", 32'(done),     32'(0));
        chk("rst_dz",   32'(div_zero), 32'(0));
        @(posedge clk);
        #1;

        // MUL 13*11: stall spans issue cycle plus 8 busy cycles.
        stall_cnt = 0;
        issue(MUL, 8'd13, 8'd11);
        wait_done();
        chk("mul_stall_cycles", 32'(stall_cnt), 32'(9));

        issue(MUL, 8'hFF, 8'hFF);
        wait_done();
        issue(MUL, 8'h00, 8'h5A);
        wait_done();
        issue(DIV, 8'd200, 8'd7);
        wait_done();
        issue(DIV, 8'd5, 8'd9);
        wait_done();

        // Divide by zero: never busy, no stall in issue cycle.
        stall_cnt = 0;
        issue(DIV, 8'h2A, 8'h00);
        chk("dz_busy", 32'(busy), 32'(0));
        wait_done();
        chk("dz_stall_cycles", 32'(stall_cnt), 32'(0));
        chk("dz_sticky", 32'(div_zero), 32'(1));
        issue(MUL, 8'd6, 8'd7);
        wait_done();

        // MFLO and DIV presented during a MUL run stall; HI/LO hold.
        prev_hi = mdl_hi;
        prev_lo = mdl_lo;
        issue(MUL, 8'd37, 8'd29);
        start = 1'b1;
        op    = MFLO;
        repeat (3) begin
            @(negedge clk);
            chk("mf_stall",    32'(stall),   32'(1));
            chk("mid_mf_data", 32'(mf_data), 32'(prev_lo));
            chk("mid_hi",      32'(hi),      32'(prev_hi));
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        issue(DIV, 8'd250, 8'd3);   // re-presented until the MUL finishes
        wait_done();
        issue(MUL, 8'd37, 8'd29);
        wait_done();
        start = 1'b1;
        op    = MFLO;
        @(negedge clk);
        chk("mflo_after", 32'(mf_data), 32'(10'd1073 & 8'hFF));
        chk("mflo_stall", 32'(stall),   32'(0));
        op = MFHI;
        #1;
        chk("mfhi_after", 32'(mf_data), 32'(1073 >> 8));
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 4'd0;

        // Reset during DIV iteration 4: abandoned, no done pulse.
        issue(DIV, 8'd99, 8'd5);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_q.delete();
        mdl_hi = '0;
        mdl_lo = '0;
        @(negedge clk);
        chk("abort_hi",   32'(hi),   32'(0));
        chk("abort_lo",   32'(lo),   32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        repeat (W + 3) @(posedge clk);
        #1;
        issue(MUL, 8'd3, 8'd4);
        wait_done();
        chk("post_reset_lo", 32'(lo), 32'(8'h0C));

        // Randomized traffic, sometimes back-to-back.
        for (int i = 0; i < 40; i++) begin
            o = ($urandom_range(0, 1) == 0) ? MUL : DIV;
            x = W'($urandom_range(0, 255));
            y = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom_range(0, 255));
            issue(o, x, y);
            if ($urandom_range(0, 1) == 0) begin
                wait_done();
                do o = 4'($urandom_range(0, 15)); while (o == MUL || o == DIV);
                exp_mf = (o == MFHI) ? mdl_hi : ((o == MFLO) ? mdl_lo : '0);
                start = 1'b1;
                op    = o;
                a     = W'($urandom);
                b     = W'($urandom);
                @(negedge clk);
                chk("other_stall", 32'(stall),   32'(0));
                chk("other_mf",    32'(mf_data), 32'(exp_mf));
                @(posedge clk);
                #1;
                start = 1'b0;
                op    = 4'd0;
                @(negedge clk);
                chk("other_hi", 32'(hi), 32'(mdl_hi));
                chk("other_lo", 32'(lo), 32'(mdl_lo));
                @(posedge clk);
                #1;
            end
        end
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide sequencer for the CPU datapath. It owns the HI/LO register pair and executes the MUL and DIV opcodes over several cycles while stalling instruction issue. It also serves HI/LO reads for MFHI/MFLO. It sits beside the single-cycle ALU and is driven by the decoded opcode and register-file read ports.

## Interface
Parameters:
- WIDTH, 8, operand/register width; HI and LO are each WIDTH bits

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  instruction valid in issue stage this cycle
- op  in  4  instruction opcode (MUL=5, MFHI=6, MFLO=7, DIV=8)
- a  in  WIDTH  rs operand (multiplicand / dividend)
- b  in  WIDTH  rt operand (multiplier / divisor)
- stall  out  1  hold PC and issue stage this cycle
- busy  out  1  iteration in progress
- done  out  1  one-cycle pulse: HI/LO just updated
- div_zero  out  1  sticky-until-next-op flag: last DIV had b==0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- mf_data  out  WIDTH  hi when op==MFHI, lo when op==MFLO, else 0 (combinational)

## Operation
- States: IDLE, MUL_RUN, DIV_RUN. All arithmetic is unsigned.
- Accept: in IDLE with start=1 and op in {MUL, DIV}, the op is latched at the edge.
  - MUL accept: acc = 0, mcand = a, mplier = b, cnt = WIDTH, then go to MUL_RUN.
  - DIV accept with b!=0: rem = 0, quot = a, dvsr = b, cnt = WIDTH, then go to DIV_RUN.
  - DIV accept with b==0: no iteration. At that same edge hi=a, lo={WIDTH{1}}, div_zero=1, and done fires the next cycle. State stays IDLE.
- MUL_RUN iteration, shift-add: if mplier[0], acc += mcand (WIDTH+1-bit sum). Then shift {carry, acc, mplier} right by 1 and decrement cnt.
- DIV_RUN iteration, restoring: shift {rem, quot} left by 1 and trial-subtract dvsr from rem (WIDTH+1 bits). If there is no borrow, keep the difference and set quot[0]=1. Decrement cnt.
- Completion: on the edge where cnt goes 1→0, return to IDLE and register done=1 for the following cycle.
  - MUL: hi = acc, lo = mplier, i.e. the 2·WIDTH product split.
  - DIV: hi = remainder, lo = quotient.
- div_zero clears on the next accepted MUL/DIV.
- start with op not MUL/DIV: no effect on state or HI/LO.
- start while busy: not accepted. The pipeline is stalled, so the instruction is re-presented after completion.
- HI/LO change only at completion. They are never partially updated during iteration.

## Timing
- Reset (reset_n=0 at an edge): state=IDLE, hi=0, lo=0, cnt=0, done=0, div_zero=0, busy=0. An in-flight op is abandoned with no completion pulse. stall is 0 while reset_n=0.
- stall = busy | (state==IDLE & start & op==MUL, or op==DIV with b!=0). It is combinational, so the issuing instruction stalls in its own cycle.
- stall = start & op in {MFHI, MFLO} & busy. An MFHI/MFLO waits until the result is ready.
- Latency, MUL or DIV with b!=0: accept at edge E0. busy=1 for cycles E0..E(WIDTH). HI/LO are written at edge E(WIDTH). done=1 during the cycle after E(WIDTH), and stall drops in that same cycle.
- Latency, DIV by zero: HI/LO written at E0. done=1 in the following cycle. busy is never asserted, and stall is 0 in the issue cycle.
- A new op may be accepted in the done cycle, because the state is already IDLE.
- mf_data reflects the registered hi/lo, so an MFHI in the done cycle returns the new value.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants OP_MUL, OP_MFHI, OP_MFLO, OP_DIV, matching the main decoder encoding;
  - the typedef enum muldiv_state_t {IDLE, MUL_RUN, DIV_RUN}.
- One natural sub-module: muldiv_datapath, which holds the acc/rem and mplier/quot shift registers, the adder/subtractor, and the counter. It is driven by load/step/kind controls from the FSM in muldiv_ctrl.

## Test plan
- MUL a=13, b=11 → after 8 busy cycles: hi=0x00, lo=0x8F, done pulses once, stall high for exactly 9 cycles including the issue cycle.
- MUL a=0xFF, b=0xFF → hi=0xFE, lo=0x01. Then MUL 0×0x5A → hi=0, lo=0.
- DIV a=200, b=7 → lo=0x1C, hi=0x04, div_zero=0. Then DIV a=5, b=9 → lo=0, hi=5.
- DIV a=0x2A, b=0 → hi=0x2A, lo=0xFF, div_zero=1, done the next cycle, busy never high. A following MUL clears div_zero.
- Start a MUL, present MFLO and a second DIV during busy → both stalled, HI/LO unchanged mid-run. MFLO after done returns the MUL low byte. The DIV is accepted only after the state returns to IDLE.
- reset_n low for 1 cycle at iteration 4 of a DIV → hi=lo=0, busy=0, no done pulse. A new MUL 3×4 then gives lo=0x0C.
